conect_result_fifo: RTL and testbench

- Downstream capture stage for the `conect` operator block.
- Accepts each 9-bit `s_out` result, tagged with the `sel` that produced it, through a valid/ready handshake.
- Buffers results in a small FWFT FIFO for a slower consumer, such as a checker or bus bridge.
- Keeps running statistics: a saturating sum of all accepted results and a count of results with bit 8 set.

---
 rtl/conect_result_fifo_if.sv | 24 ++
 rtl/conect_result_fifo.sv | 115 +++++++++++
 tb/tb_conect_result_fifo.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/conect_result_fifo_if.sv
// Result handshake bundle between the conect operator, the capture FIFO
// and its downstream consumer.
interface conect_result_fifo_if;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_data;
    logic [1:0] in_sel;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_data;
    logic [1:0] out_sel;

    // FIFO side: accepts results, presents the head entry
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/conect_result_fifo.sv
// Capture stage for conect results: FWFT FIFO of {sel, s_out} entries plus
// running statistics (saturating sum and count of words with bit 8 set).
module conect_result_fifo #(
    parameter int DEPTH = 4,
    parameter int ACC_W = 12,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    conect_result_fifo_if.slave      bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [ACC_W-1:0]         acc,
    output logic                     acc_sat,
    output logic [CNT_W-1:0]         carry_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Returns {overflow, clamped sum}
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [8:0]       d);
        logic [ACC_W:0] s;
        s = {1'b0, a} + (ACC_W+1)'(d);
        if (s[ACC_W]) begin
            sat_add = {1'b1, {ACC_W{1'b1}}};
        end else begin
            sat_add = s;
        end
    endfunction

    logic [10:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             acc_sat_q, acc_sat_d;
    logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;
    logic [ACC_W:0]   sum_w;
    logic             push, pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign {bus.out_sel, bus.out_data} = empty ? 11'd0 : mem_q[rd_ptr_q];

    // A full FIFO refuses pushes even when a pop happens on the same edge
    assign push = bus.in_valid && !full;
    assign pop  = !empty && bus.out_ready;

    assign acc       = acc_q;
    assign acc_sat   = acc_sat_q;
    assign carry_cnt = carry_cnt_q;

    // Next-state for pointers, occupancy and statistics
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        acc_d       = acc_q;
        acc_sat_d   = acc_sat_q;
        carry_cnt_d = carry_cnt_q;
        sum_w       = sat_add(acc_q, bus.in_data);

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // clr takes priority over a simultaneous push
        if (clr) begin
            acc_d       = '0;
            acc_sat_d   = 1'b0;
            carry_cnt_d = '0;
        end else if (push) begin
            acc_d     = sum_w[ACC_W-1:0];
            acc_sat_d = acc_sat_q | sum_w[ACC_W];
            if (bus.in_data[8] && (carry_cnt_q != {CNT_W{1'b1}})) begin
                carry_cnt_d = carry_cnt_q + CNT_W'(1);
            end
        end
    end

    // Control and statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            acc_sat_q   <= 1'b0;
            carry_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            acc_sat_q   <= acc_sat_d;
            carry_cnt_q <= carry_cnt_d;
        end
    end

    // Entry storage; contents only matter while counted as occupied
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.in_sel, bus.in_data};
    end
endmodule

// File: tb/tb_conect_result_fifo.sv
// Directed bench for conect_result_fifo (DEPTH=4, ACC_W=12, CNT_W=8).
module tb_conect_result_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] count;
    logic       full, empty;
    logic [11:0] acc;
    logic       acc_sat;
    logic [7:0] carry_cnt;
    int         tests = 0;
    int         fails = 0;
    logic [10:0] exp_q[$];
    logic [10:0] tmp;

    conect_result_fifo_if ifc ();

    conect_result_fifo #(.DEPTH(4), .ACC_W(12), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifc),
        .count(count), .full(full), .empty(empty),
        .acc(acc), .acc_sat(acc_sat), .carry_cnt(carry_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_ovalid"}, 32'(ifc.out_valid), 0);
        chk({tag, "_iready"}, 32'(ifc.in_ready), 1);
        chk({tag, "_odata"}, 32'(ifc.out_data), 0);
        chk({tag, "_osel"}, 32'(ifc.out_sel), 0);
        chk({tag, "_acc"}, 32'(acc), 0);
        chk({tag, "_sat"}, 32'(acc_sat), 0);
        chk({tag, "_carry"}, 32'(carry_cnt), 0);
    endtask

    initial begin
        ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.in_sel = '0; ifc.out_ready = 1'b0;
        // 1: reset and idle
        tick(); tick();
        chk_reset("rst");
        rst_n = 1'b1;
        tick();
        chk_reset("idle");

        // 2: two pushes with consumer stalled
        ifc.in_valid = 1'b1; ifc.in_data = 9'h1FE; ifc.in_sel = 2'd0;
        tick();
        chk("p1_count", 32'(count), 1);
        chk("p1_ovalid", 32'(ifc.out_valid), 1);
        chk("p1_odata", 32'(ifc.out_data), 32'h1FE);
        chk("p1_osel", 32'(ifc.out_sel), 0);
        ifc.in_data = 9'h000; ifc.in_sel = 2'd1;
        tick();
        ifc.in_valid = 1'b0;
        chk("p2_count", 32'(count), 2);
        chk("p2_acc", 32'(acc), 510);
        chk("p2_carry", 32'(carry_cnt), 1);
        chk("p2_odata", 32'(ifc.out_data), 32'h1FE);
        ifc.out_ready = 1'b1;
        tick();
        chk("pop1_odata", 32'(ifc.out_data), 32'h000);
        chk("pop1_osel", 32'(ifc.out_sel), 1);
        chk("pop1_acc", 32'(acc), 510);
        tick();
        chk("pop2_empty", 32'(empty), 1);
        chk("pop2_odata", 32'(ifc.out_data), 0);
        ifc.out_ready = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_acc", 32'(acc), 0);
        chk("clr_carry", 32'(carry_cnt), 0);

        // 3: overfill, then one pop lets the held word in
        ifc.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ifc.in_data = 9'(9'h101 + i); ifc.in_sel = 2'(i);
            tick();
        end
        chk("full_flag", 32'(full), 1);
        chk("full_iready", 32'(ifc.in_ready), 0);
        chk("full_count", 32'(count), 4);
        chk("full_acc", 32'(acc), 1034);
        ifc.in_data = 9'h105; ifc.in_sel = 2'd0;
        tick();
        chk("held_count", 32'(count), 4);
        chk("held_acc", 32'(acc), 1034);
        chk("held_carry", 32'(carry_cnt), 4);
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        chk("fpop_count", 32'(count), 3);
        chk("fpop_iready", 32'(ifc.in_ready), 1);
        chk("fpop_odata", 32'(ifc.out_data), 32'h102);
        chk("fpop_osel", 32'(ifc.out_sel), 1);
        tick();
        ifc.in_valid = 1'b0;
        chk("late_count", 32'(count), 4);
        chk("late_acc", 32'(acc), 1295);
        chk("late_carry", 32'(carry_cnt), 5);

        // 4: steady push+pop at half full across pointer wrap
        ifc.out_ready = 1'b1;
        tick(); tick();
        ifc.out_ready = 1'b0;
        chk("half_count", 32'(count), 2);
        chk("half_odata", 32'(ifc.out_data), 32'h104);
        exp_q.delete();
        exp_q.push_back({2'd3, 9'h104});
        exp_q.push_back({2'd0, 9'h105});
        ifc.in_valid = 1'b1; ifc.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ifc.in_data = 9'(9'h0A0 + i); ifc.in_sel = 2'(i);
            tick();
            tmp = exp_q.pop_front();
            exp_q.push_back({2'(i), 9'(9'h0A0 + i)});
            chk("stream_count", 32'(count), 2);
            chk("stream_head", 32'({ifc.out_sel, ifc.out_data}), 32'(exp_q[0]));
        end
        ifc.in_valid = 1'b0;
        tick();
        chk("drain_head", 32'({ifc.out_sel, ifc.out_data}), 32'(exp_q[1]));
        tick();
        chk("drain_empty", 32'(empty), 1);
        chk("drain_ovalid", 32'(ifc.out_valid), 0);

        // 5: accumulator saturation and clr against a push
        clr = 1'b1;
        tick();
        clr = 1'b0;
        ifc.in_valid = 1'b1; ifc.in_data = 9'h1FE; ifc.in_sel = 2'd3;
        for (int i = 0; i < 8; i++) tick();
        chk("sat8_acc", 32'(acc), 4080);
        chk("sat8_flag", 32'(acc_sat), 0);
        chk("sat8_carry", 32'(carry_cnt), 8);
        chk("sat8_count", 32'(count), 1);
        tick();
        chk("sat9_acc", 32'(acc), 4095);
        chk("sat9_flag", 32'(acc_sat), 1);
        tick();
        chk("sat10_acc", 32'(acc), 4095);
        chk("sat10_flag", 32'(acc_sat), 1);
        chk("sat10_carry", 32'(carry_cnt), 10);
        ifc.out_ready = 1'b0; clr = 1'b1;
        ifc.in_data = 9'h155; ifc.in_sel = 2'd2;
        tick();
        clr = 1'b0; ifc.in_valid = 1'b0;
        chk("clrp_acc", 32'(acc), 0);
        chk("clrp_sat", 32'(acc_sat), 0);
        chk("clrp_carry", 32'(carry_cnt), 0);
        chk("clrp_count", 32'(count), 2);
        ifc.out_ready = 1'b1;
        tick();
        chk("clrp_head", 32'({ifc.out_sel, ifc.out_data}), 32'({2'd2, 9'h155}));
        chk("clrp_popacc", 32'(acc), 0);
        tick();
        ifc.out_ready = 1'b0;
        chk("clrp_empty", 32'(empty), 1);

        // 6: asynchronous reset mid-cycle
        ifc.in_valid = 1'b1; ifc.in_data = 9'h1AA; ifc.in_sel = 2'd1;
        tick();
        ifc.in_data = 9'h011;
        tick();
        ifc.in_data = 9'h022;
        tick();
        ifc.in_valid = 1'b0;
        chk("pre_count", 32'(count), 3);
        chk("pre_acc", 32'(acc), 477);
        chk("pre_carry", 32'(carry_cnt), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset("arst");
        tick();
        rst_n = 1'b1;
        chk_reset("arst_hold");
        ifc.in_valid = 1'b1; ifc.in_data = 9'h0F0; ifc.in_sel = 2'd1;
        tick();
        ifc.in_valid = 1'b0;
        chk("resume_count", 32'(count), 1);
        chk("resume_head", 32'({ifc.out_sel, ifc.out_data}), 32'({2'd1, 9'h0F0}));
        chk("resume_acc", 32'(acc), 240);
        chk("resume_carry", 32'(carry_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
